// File: rtl/matrix_multiply_core_3x3_coef_unpack.sv
// Coefficient loader for the 3x3 matrix-multiply core: unpacks 5 bus words into a shadow bank
// and commits all 9 coefficients at once. Optional readback port: define MM3X3_COEF_READBACK_EN.
module matrix_multiply_core_3x3_coef_unpack #(
  parameter int COEF_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic                  abort,
  output logic [9*COEF_W-1:0]   coef_flat,
  output logic                  coef_update,
  output logic                  busy
`ifdef MM3X3_COEF_READBACK_EN
  ,
  input  logic [2:0]            rd_addr,
  output logic [31:0]           rd_data
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [COEF_W-1:0]    shadow_q [9];
  logic [9*COEF_W-1:0]  coef_q;
  logic                 upd_q;
  logic                 accept;
  logic                 commit_now;

  // Half-word bits above COEF_W are dropped on purpose (no saturation).
  logic unused_word_bits;
  assign unused_word_bits = ^word_in;

  assign word_ready  = (state_q != COMMIT) && !abort;
  assign accept      = word_valid && word_ready;
  assign commit_now  = (state_q == COMMIT) && !abort;
  assign coef_flat   = coef_q;
  assign coef_update = upd_q;
  assign busy        = (cnt_q != 3'd0) || (state_q == COMMIT);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = FILL;
            cnt_d   = 3'd1;
          end
        end
        FILL: begin
          if (accept) begin
            if (cnt_q == 3'd4) begin
              state_d = COMMIT;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        COMMIT: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the shadow bank is reset too, so a fresh part never holds X coefficients.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) shadow_q[i] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 5; k++) begin
        if (cnt_q == 3'(k)) begin
          shadow_q[2*k] <= word_in[COEF_W-1:0];
          if (k < 4) shadow_q[2*k+1] <= word_in[16 +: COEF_W];
        end
      end
    end
  end

  // All 9 coefficients move together on the commit edge; an abort here cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= commit_now;
      if (commit_now) begin
        for (int i = 0; i < 9; i++) coef_q[i*COEF_W +: COEF_W] <= shadow_q[i];
      end
    end
  end

`ifdef MM3X3_COEF_READBACK_EN
  logic [31:0] rd_d, rd_q;

  function automatic logic [15:0] sext(input logic [COEF_W-1:0] c);
    logic signed [COEF_W-1:0] s;
    s = c;
    return 16'(s);
  endfunction

  // Reads the active bank, so a read in the commit cycle still sees the old set.
  always_comb begin
    rd_d = '0;
    for (int a = 0; a < 5; a++) begin
      if (rd_addr == 3'(a)) begin
        rd_d[15:0] = sext(coef_q[(2*a)*COEF_W +: COEF_W]);
        if (a < 4) rd_d[31:16] = sext(coef_q[(2*a+1)*COEF_W +: COEF_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_matrix_multiply_core_3x3_coef_unpack.sv
// Directed bench for the coefficient loader; two instances (COEF_W 16 and 12) share stimulus.
module tb_matrix_multiply_core_3x3_coef_unpack;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         abort;
  logic         ready16, ready12, upd16_o, upd12_o, busy16, busy12;
  logic [143:0] flat16;
  logic [107:0] flat12;
`ifdef MM3X3_COEF_READBACK_EN
  logic [2:0]   rd_addr;
  logic [31:0]  rd16, rd12;
`endif

  int total = 0;
  int bad   = 0;
  int upd16 = 0;
  int upd12 = 0;

  always #5 clk = ~clk;

  matrix_multiply_core_3x3_coef_unpack #(.COEF_W(16)) dut16 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(ready16),
    .abort(abort), .coef_flat(flat16), .coef_update(upd16_o), .busy(busy16)
`ifdef MM3X3_COEF_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd16)
`endif
  );

  matrix_multiply_core_3x3_coef_unpack #(.COEF_W(12)) dut12 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(ready12),
    .abort(abort), .coef_flat(flat12), .coef_update(upd12_o), .busy(busy12)
`ifdef MM3X3_COEF_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd12)
`endif
  );

  always @(negedge clk) begin
    if (!rst && upd16_o) upd16++;
    if (!rst && upd12_o) upd12++;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] f16(input int v [9]);
    logic [143:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*16 +: 16] = 16'(v[i]);
    return r;
  endfunction

  function automatic logic [107:0] f12(input int v [9]);
    logic [107:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*12 +: 12] = 12'(v[i]);
    return r;
  endfunction

  task automatic send_word(input logic [31:0] w);
    int n;
    word_in    = w;
    word_valid = 1'b1;
    n = 0;
    while (!ready16 && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("ready_timeout", 1'b0, 1'b1);
    step();
  endtask

  task automatic send_frame(input logic [31:0] w [5]);
    for (int i = 0; i < 5; i++) send_word(w[i]);
    word_valid = 1'b0;
  endtask

  task automatic commit_frame(input string tag, input logic [31:0] w [5],
                              input logic [143:0] e16, input logic [107:0] e12);
    logic [143:0] old16;
    logic [107:0] old12;
    int p16, p12;
    old16 = flat16;
    old12 = flat12;
    p16   = upd16;
    p12   = upd12;
    send_frame(w);
    check({tag, "_commit_ready"}, ready16, 1'b0);
    check({tag, "_commit_busy"}, busy16, 1'b1);
    check({tag, "_commit_noupd"}, upd16_o, 1'b0);
    check({tag, "_hold16"}, flat16, old16);
    check({tag, "_hold12"}, flat12, old12);
    step();
    check({tag, "_upd16"}, upd16_o, 1'b1);
    check({tag, "_upd12"}, upd12_o, 1'b1);
    check({tag, "_flat16"}, flat16, e16);
    check({tag, "_flat12"}, flat12, e12);
    check({tag, "_busy_after"}, busy16, 1'b0);
    check({tag, "_ready_after"}, ready16, 1'b1);
    step();
    check({tag, "_upd_drop"}, upd16_o, 1'b0);
    check({tag, "_pulses16"}, upd16 - p16, 1);
    check({tag, "_pulses12"}, upd12 - p12, 1);
  endtask

  initial begin
    logic [31:0]  fr [5];
    int           ev16 [9];
    int           ev12 [9];
    logic [143:0] keep16;
    logic [107:0] keep12;
    int           p16, acc;

    rst        = 1'b1;
    word_in    = '0;
    word_valid = 1'b0;
    abort      = 1'b0;
`ifdef MM3X3_COEF_READBACK_EN
    rd_addr    = 3'd0;
`endif
    step();
    step();
    rst = 1'b0;

    check("rst_flat16", flat16, '0);
    check("rst_flat12", flat12, '0);
    check("rst_upd", upd16_o, 1'b0);
    check("rst_busy", busy16, 1'b0);
    check("rst_ready", ready16, 1'b1);
`ifdef MM3X3_COEF_READBACK_EN
    check("rst_rd", rd12, '0);
`endif

    // Frame 1: coef i = i+1; word 4 upper half must vanish.
    fr   = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007, 32'hFFFF_0009};
    ev16 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    commit_frame("f1", fr, f16(ev16), f12(ev16));

    // Partial frame then abort; then an all-zero frame.
    p16 = upd16;
    send_word(32'h1111_2222);
    send_word(32'h3333_4444);
    send_word(32'h5555_6666);
    check("ab_busy", busy16, 1'b1);
    abort = 1'b1;
    word_in = 32'hDEAD_BEEF;
    #1;
    check("ab_ready", ready16, 1'b0);
    step();
    abort = 1'b0;
    word_valid = 1'b0;
    check("ab_busy_clear", busy16, 1'b0);
    step();
    step();
    check("ab_nopulse", upd16 - p16, 0);
    check("ab_hold16", flat16, f16(ev16));
    fr   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ev16 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    commit_frame("zero", fr, f16(ev16), f12(ev16));

    // Width truncation: 0x7ABC_F123 as word 0.
    fr   = '{32'h7ABC_F123, 32'h0044_0033, 32'h0066_0055, 32'h0088_0077, 32'h1234_0099};
    ev16 = '{'hF123, 'h7ABC, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88, 'h99};
    ev12 = '{'h123, 'hABC, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88, 'h99};
    commit_frame("trunc", fr, f16(ev16), f12(ev12));

    // Abort during COMMIT: nothing changes, no pulse.
    keep16 = flat16;
    keep12 = flat12;
    p16    = upd16;
    fr     = '{32'h0101_0202, 32'h0303_0404, 32'h0505_0606, 32'h0707_0808, 32'h0909_0A0A};
    send_frame(fr);
    check("ac_in_commit", busy16, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ac_busy", busy16, 1'b0);
    check("ac_hold16", flat16, keep16);
    check("ac_hold12", flat12, keep12);
    step();
    check("ac_noupd", upd16_o, 1'b0);
    check("ac_nopulse", upd16 - p16, 0);

    // word_valid held high for 12 cycles.
    p16 = upd16;
    acc = 0;
    for (int c = 1; c <= 12; c++) begin
      word_in    = {16'(2 * c), 16'(2 * c - 1)};
      word_valid = 1'b1;
      #1;
      if (c == 6 || c == 12) check($sformatf("cont_ready_c%0d", c), ready16, 1'b0);
      if (ready16) acc++;
      step();
    end
    word_valid = 1'b0;
    check("cont_accepted", acc, 10);
    ev16 = '{13, 14, 15, 16, 17, 18, 19, 20, 21};
    check("cont_upd", upd16_o, 1'b1);
    check("cont_flat16", flat16, f16(ev16));
    check("cont_flat12", flat12, f12(ev16));
    step();
    check("cont_pulses", upd16 - p16, 2);

`ifdef MM3X3_COEF_READBACK_EN
    // Readback: sign extension, commit-cycle read, out-of-range addresses.
    rd_addr = 3'd0;
    fr = '{32'h0ABC_0800, 32'h0, 32'h0, 32'h0, 32'h5555_0123};
    send_frame(fr);
    step();
    check("rd_commit_old12", rd12, 32'h000E_000D);
    check("rd_commit_upd", upd16_o, 1'b1);
    step();
    check("rd_a0_12", rd12, 32'hFABC_F800);
    check("rd_a0_16", rd16, 32'h0ABC_0800);
    rd_addr = 3'd4;
    step();
    check("rd_a4_12", rd12, 32'h0000_0123);
    rd_addr = 3'd6;
    step();
    check("rd_a6_12", rd12, 32'h0);
`endif

    // Reset mid-frame returns to reset values.
    send_word(32'h1234_5678);
    send_word(32'h1234_5678);
    word_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", busy16, 1'b0);
    check("mrst_flat16", flat16, '0);
    check("mrst_flat12", flat12, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_multiply_core_3x3_coef_unpack.md
# matrix_multiply_core_3x3_coef_unpack

Bus-side coefficient loader for the 3x3 matrix-multiply core. It accepts a stream of packed 32-bit bus words and unpacks each into two coefficient fields. It assembles a full 3x3 coefficient set in a shadow bank, then commits it atomically to the active bank that drives the core's coefficient inputs. It is the unpacking counterpart of the bit-packing bus builders that assemble the core's 32-bit output words.

## Interface
Parameters:
- COEF_W, 16: coefficient width, 2..16. Each coefficient occupies the low COEF_W bits of a 16-bit half-word.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- word_in  input  32  packed coefficient word: [15:0] holds the even coefficient, [31:16] the odd coefficient
- word_valid  input  1  word_in is valid
- word_ready  output  1  block accepts word_in this cycle
- abort  input  1  discard the partially loaded frame
- coef_flat  output  9*COEF_W  active bank; coefficient i (row-major, i = 3*row + col) at [i*COEF_W +: COEF_W]
- coef_update  output  1  one-cycle pulse, valid in the same cycle as a newly committed coef_flat
- busy  output  1  frame in progress (word count nonzero or COMMIT state)

## Operation
- The frame is 5 words. Word k (0..4) writes shadow[2k] from word_in[COEF_W-1:0]. It writes shadow[2k+1] from word_in[16+COEF_W-1:16]. Word 4's upper half is ignored.
- Bits above COEF_W in each half are discarded. No saturation.
- A word is accepted when word_valid && word_ready at a rising edge.
- word_ready = (state != COMMIT) && !abort. The signal is combinational, and word_valid does not feed it.
- FSM states:
  - IDLE: cnt = 0. An accepted word goes to FILL with cnt = 1.
  - FILL: each accepted word increments cnt. Acceptance of word 4 goes to COMMIT.
  - COMMIT: lasts one cycle. Active bank <= shadow, coef_update <= 1, then the FSM returns to IDLE.
- abort has priority over everything. When asserted, the next state is IDLE with cnt = 0, and no word is accepted. An abort during COMMIT suppresses the commit, so the active bank is unchanged and no pulse is issued.
- The shadow bank is not cleared on abort. Stale shadow contents are never exposed because a commit requires 5 fresh words.
- Idle cycles (word_valid low) inside a frame are allowed with no timeout.

## Timing
- Reset values: coef_flat = 0, coef_update = 0, busy = 0, state IDLE, cnt = 0, shadow = 0. word_ready = 1 after reset when abort is low.
- Word 4 is accepted at edge N. During cycle N..N+1 the FSM is in COMMIT and word_ready = 0. After edge N+1, coef_flat holds the new set and coef_update = 1 for exactly one cycle.
- Back-to-back throughput: 6 cycles per frame (5 accept cycles plus 1 COMMIT).
- coef_flat changes only at the commit edge. All 9 coefficients change in the same cycle, with no partial updates.
- A reset asserted mid-frame or during COMMIT returns everything to reset values at the next edge.

## Configuration
- MM3X3_COEF_READBACK_EN
  - Defined: adds ports rd_addr (input, 3 bits) and rd_data (output, 32 bits, registered, 1-cycle latency, reset 0).
    - Addresses 0..4 return the active bank in the same packing as word_in. Each coefficient is sign-extended from COEF_W to 16 bits.
    - rd_data[31:16] at address 4 reads 0. Addresses 5..7 read 0.
    - A read in the commit cycle returns the pre-commit values. The new values are visible from the next read.
  - Undefined: rd_addr, rd_data and the readback logic are absent. All other behaviour is identical.

## Test plan
- Reset, then 5 back-to-back words 0x0002_0001, 0x0004_0003, 0x0006_0005, 0x0008_0007, 0xFFFF_0009 → coef i = i+1 for i = 0..8. coef_update is high exactly one cycle, 1 cycle after word 4 is accepted. The ignored upper half leaves nothing visible.
- 3 words, then abort, then 5 fresh words of 0x0000_0000 → no pulse after the abort. Then one pulse with all coefficients 0. The prior active values are held until that commit.
- Abort asserted in the COMMIT cycle of a full frame → coef_flat unchanged, coef_update never asserted, busy = 0 on the next cycle.
- COEF_W = 12, word 0x7ABC_F123 as word 0 of a full frame → coef0 = 0x123, coef1 = 0xABC.
- word_valid held high continuously for 12 words → exactly 2 commits, word_ready low on cycles 6 and 12, and 10 words accepted.
- With MM3X3_COEF_READBACK_EN and COEF_W = 12, coef0 = 0x800 → rd_addr = 0 returns 0x????_F800 with the correct upper half one cycle later. rd_addr = 6 returns 0.
